iomem_timer: RTL

//   Responder on the picosoc iomem bus: a memory-mapped prescaled timer with compare match and interrupt.

---
 rtl/iomem_timer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// Prescaled 32-bit timer with compare match and interrupt, mapped as a responder
// on the picosoc iomem bus. Single-cycle registered ack; byte-strobed writes.
module iomem_timer #(
    parameter logic [31:0]           BASE_ADDR      = 32'h0300_0000,
    parameter int                    PRESCALE_W     = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RESET = '0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_COMPARE  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    logic                  ready_reg,       ready_next;
    logic [31:0]           rdata_reg,       rdata_next;
    logic                  en_reg,          en_next;
    logic                  auto_reload_reg, auto_reload_next;
    logic                  irq_en_reg,      irq_en_next;
    logic [PRESCALE_W-1:0] prescale_reg,    prescale_next;
    logic [PRESCALE_W-1:0] presc_cnt_reg,   presc_cnt_next;
    logic [31:0]           count_reg,       count_next;
    logic [31:0]           compare_reg,     compare_next;
    logic                  match_reg,       match_next;

    logic                  sel;
    logic [7:0]            offset;
    logic                  bus_wr;
    logic                  wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic [31:0]           byte_mask;
    logic [PRESCALE_W-1:0] presc_mask;
    logic                  tick;
    logic                  hit;
    logic [31:0]           rd_mux;

    assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign offset = iomem_addr[7:0];

    // Writes land on the edge that closes the ready cycle; valid is still held then.
    assign bus_wr      = ready_reg && sel && (iomem_wstrb != 4'b0000);
    assign wr_ctrl     = bus_wr && (offset == OFF_CTRL);
    assign wr_prescale = bus_wr && (offset == OFF_PRESCALE);
    assign wr_count    = bus_wr && (offset == OFF_COUNT);
    assign wr_compare  = bus_wr && (offset == OFF_COMPARE);
    assign wr_status   = bus_wr && (offset == OFF_STATUS);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    assign presc_mask = byte_mask[PRESCALE_W-1:0];

    // >= rather than == so that shrinking PRESCALE below the running count still ticks.
    assign tick = en_reg && (presc_cnt_reg >= prescale_reg);
    assign hit  = tick && (count_reg == compare_reg);

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_CTRL:     rd_mux = {29'd0, irq_en_reg, auto_reload_reg, en_reg};
            OFF_PRESCALE: rd_mux = 32'(prescale_reg);
            OFF_COUNT:    rd_mux = count_reg;
            OFF_COMPARE:  rd_mux = compare_reg;
            OFF_STATUS:   rd_mux = {31'd0, match_reg};
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        ready_next       = sel && !ready_reg;
        rdata_next       = (sel && !ready_reg) ? rd_mux : '0;
        en_next          = en_reg;
        auto_reload_next = auto_reload_reg;
        irq_en_next      = irq_en_reg;
        prescale_next    = prescale_reg;
        presc_cnt_next   = presc_cnt_reg;
        count_next       = count_reg;
        compare_next     = compare_reg;
        match_next       = match_reg;

        if (!en_reg) begin
            presc_cnt_next = '0;
        end else if (tick) begin
            presc_cnt_next = '0;
        end else begin
            presc_cnt_next = presc_cnt_reg + 1'b1;
        end

        if (tick) begin
            if (hit) begin
                if (auto_reload_reg) begin
                    count_next = '0;
                end else begin
                    en_next = 1'b0;
                end
            end else begin
                count_next = count_reg + 32'd1;
            end
        end

        // Bus writes are applied after the timer update so they take priority.
        if (wr_ctrl && iomem_wstrb[0]) begin
            en_next          = iomem_wdata[0];
            auto_reload_next = iomem_wdata[1];
            irq_en_next      = iomem_wdata[2];
        end
        if (wr_prescale) begin
            prescale_next = (prescale_reg & ~presc_mask) | (iomem_wdata[PRESCALE_W-1:0] & presc_mask);
        end
        if (wr_count) begin
            count_next = (count_reg & ~byte_mask) | (iomem_wdata & byte_mask);
        end
        if (wr_compare) begin
            compare_next = (compare_reg & ~byte_mask) | (iomem_wdata & byte_mask);
        end
        if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
            match_next = 1'b0;
        end

        // A fresh match outranks a simultaneous clear.
        if (hit) begin
            match_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_reg       <= 1'b0;
            rdata_reg       <= '0;
            en_reg          <= 1'b0;
            auto_reload_reg <= 1'b0;
            irq_en_reg      <= 1'b0;
            prescale_reg    <= PRESCALE_RESET;
            presc_cnt_reg   <= '0;
            count_reg       <= '0;
            compare_reg     <= '0;
            match_reg       <= 1'b0;
        end else begin
            ready_reg       <= ready_next;
            rdata_reg       <= rdata_next;
            en_reg          <= en_next;
            auto_reload_reg <= auto_reload_next;
            irq_en_reg      <= irq_en_next;
            prescale_reg    <= prescale_next;
            presc_cnt_reg   <= presc_cnt_next;
            count_reg       <= count_next;
            compare_reg     <= compare_next;
            match_reg       <= match_next;
        end
    end

    assign iomem_ready = ready_reg;
    assign iomem_rdata = rdata_reg;
    assign irq         = match_reg & irq_en_reg;

endmodule
